// File: rtl/timebase_scan_controller_if.sv
// Timebase / scan controller bus.
// Groups the command inputs (start, stop, pause) and the timing outputs
// (second tick, minute tick, seconds count, state flags, column scan).
//   master : drives start/stop/pause, observes all timing outputs
//   slave  : the controller itself
// N_COLS must match the controller's N_COLS parameter.
interface timebase_scan_controller_if #(
    parameter int N_COLS = 5
);
    localparam int CW = $clog2(N_COLS);

    logic              start;
    logic              stop;
    logic              pause;
    logic              sec_tick;
    logic              min_tick;
    logic [5:0]        sec_count;
    logic              running;
    logic              paused;
    logic              scan_tick;
    logic [CW-1:0]     col_idx;
    logic [N_COLS-1:0] col_sel;

    modport master (
        output start, stop, pause,
        input  sec_tick, min_tick, sec_count, running, paused,
        input  scan_tick, col_idx, col_sel
    );

    modport slave (
        input  start, stop, pause,
        output sec_tick, min_tick, sec_count, running, paused,
        output scan_tick, col_idx, col_sel
    );
endinterface

// File: rtl/timebase_scan_controller.sv
// timebase_scan_controller
// Single-clock timebase and LED column scan sequencer. Produces one-cycle
// enables instead of divided clocks:
//   - sec_tick every SEC_DIV cycles while RUN, 0..59 seconds count, min_tick
//     on the 59->0 wrap; IDLE/RUN/PAUSE FSM with stop > start > pause.
//   - free-running scan_tick every SCAN_DIV cycles, col_idx 0..N_COLS-1 and
//     a one-hot col_sel.
// Ports:
//   clock    system clock, everything on the rising edge
//   reset_n  synchronous reset, active-low
//   bus      timebase_scan_controller_if.slave (commands in, timing out)
// Build option:
//   SCAN_BLANK_EN  when defined, col_sel is all-zero during every scan_tick
//                  cycle (one-cycle blank between columns to avoid ghosting).
module timebase_scan_controller #(
    parameter int SEC_DIV  = 50000000,
    parameter int SCAN_DIV = 32768,
    parameter int N_COLS   = 5
) (
    input  logic                           clock,
    input  logic                           reset_n,
    timebase_scan_controller_if.slave      bus
);
    localparam int SW  = $clog2(SEC_DIV);
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int CW  = $clog2(N_COLS);

    localparam logic [SW-1:0]  SEC_LAST  = SW'(SEC_DIV - 1);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(N_COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              clr;      // start or stop this cycle: timebase restarts from zero
    logic              sec_en;   // sec prescaler advances this cycle

    logic [SW-1:0]     sec_pre_q;
    logic              sec_tick_q;
    logic [5:0]        sec_count_q;
    logic [SCW-1:0]    scan_pre_q;
    logic              scan_tick_q;
    logic [CW-1:0]     col_idx_q;
    logic [N_COLS-1:0] col_sel;

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        if (bus.stop) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
        end else if (bus.start) begin
            state_d = ST_RUN;
            clr     = 1'b1;
        end else if (bus.pause) begin
            case (state_q)
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end
        // The edge that samples pause still counts in RUN; that keeps the
        // resumed tick exactly SEC_DIV counted cycles after start.
        sec_en = (state_q == ST_RUN) && !clr;
    end

    // ---------------- seconds timebase ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sec_pre_q   <= '0;
            sec_tick_q  <= 1'b0;
            sec_count_q <= '0;
        end else begin
            if (clr)
                sec_pre_q <= '0;
            else if (sec_en)
                sec_pre_q <= (sec_pre_q == SEC_LAST) ? '0 : sec_pre_q + SW'(1);

            sec_tick_q <= sec_en && (sec_pre_q == SEC_LAST);

            // A tick in flight when start/stop lands is still visible, but
            // the clear takes precedence over its increment.
            if (clr)
                sec_count_q <= '0;
            else if (sec_tick_q)
                sec_count_q <= (sec_count_q == 6'd59) ? 6'd0 : sec_count_q + 6'd1;
        end
    end

    // ---------------- column scan ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scan_pre_q  <= '0;
            scan_tick_q <= 1'b0;
            col_idx_q   <= '0;
        end else begin
            scan_pre_q  <= (scan_pre_q == SCAN_LAST) ? '0 : scan_pre_q + SCW'(1);
            scan_tick_q <= (scan_pre_q == SCAN_LAST);
            if (scan_tick_q)
                col_idx_q <= (col_idx_q == COL_LAST) ? '0 : col_idx_q + CW'(1);
        end
    end

    always_comb begin
        col_sel            = '0;
        col_sel[col_idx_q] = 1'b1;
`ifdef SCAN_BLANK_EN
        if (scan_tick_q) col_sel = '0;
`endif
    end

    // ---------------- outputs ----------------
    assign bus.sec_tick  = sec_tick_q;
    assign bus.min_tick  = sec_tick_q && (sec_count_q == 6'd59);
    assign bus.sec_count = sec_count_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.paused    = (state_q == ST_PAUSE);
    assign bus.scan_tick = scan_tick_q;
    assign bus.col_idx   = col_idx_q;
    assign bus.col_sel   = col_sel;
endmodule

// File: tb/tb_timebase_scan_controller.sv
module tb_timebase_scan_controller;
    localparam int SEC_DIV  = 10;
    localparam int SCAN_DIV = 4;
    localparam int N_COLS   = 5;
`ifdef SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    timebase_scan_controller_if #(.N_COLS(N_COLS)) bus ();

    timebase_scan_controller #(
        .SEC_DIV (SEC_DIV),
        .SCAN_DIV(SCAN_DIV),
        .N_COLS  (N_COLS)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timebase: count RUN edges since the last clear; a tick follows every
    // SEC_DIV-th counted edge. Seconds = ticks completed since clear, mod 60.
    // Scan: closed form in edges since reset.
    int     m_state = 0;          // 0 idle, 1 run, 2 pause
    longint run_edges = 0;
    longint ticks_done = 0;
    bit     e_tick = 0;
    longint n_scan = 0;
    bit     m_valid = 0;

    always @(posedge clock) begin
        bit clr, counted;
        if (!reset_n) begin
            m_state = 0; run_edges = 0; ticks_done = 0; e_tick = 0; n_scan = 0;
        end else begin
            n_scan++;
            clr = bus.start || bus.stop;
            if (e_tick) ticks_done++;
            counted = (m_state == 1) && !clr;
            if (clr) begin run_edges = 0; ticks_done = 0; end
            if (counted) run_edges++;
            e_tick = counted && (run_edges % SEC_DIV == 0);
            if (bus.stop)        m_state = 0;
            else if (bus.start)  m_state = 1;
            else if (bus.pause)  m_state = (m_state == 1) ? 2 : (m_state == 2) ? 1 : 0;
        end
        m_valid = 1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            int    col;
            bit    stk;
            logic [N_COLS-1:0] sel;
            stk = (n_scan > 0) && (n_scan % SCAN_DIV == 0);
            col = (n_scan == 0) ? 0 : int'(((n_scan - 1) / SCAN_DIV) % N_COLS);
            sel = '0;
            sel[col] = 1'b1;
            if (BLANK && stk) sel = '0;
            check("m_sec_tick",  bus.sec_tick,  e_tick);
            check("m_min_tick",  bus.min_tick,  e_tick && (ticks_done % 60 == 59));
            check("m_sec_count", bus.sec_count, ticks_done % 60);
            check("m_running",   bus.running,   m_state == 1);
            check("m_paused",    bus.paused,    m_state == 2);
            check("m_scan_tick", bus.scan_tick, stk);
            check("m_col_idx",   bus.col_idx,   col);
            check("m_col_sel",   bus.col_sel,   sel);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clock);
            #2;
        end
    endtask

    // One-cycle command; returns 2 time units after the sampling edge.
    task automatic cmd(input bit s, input bit t, input bit p);
        bus.start = s; bus.stop = t; bus.pause = p;
        cyc(1);
        bus.start = 0; bus.stop = 0; bus.pause = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_running"},   bus.running,   0);
        check({tag, "_paused"},    bus.paused,    0);
        check({tag, "_sec_count"}, bus.sec_count, 0);
        check({tag, "_sec_tick"},  bus.sec_tick,  0);
        check({tag, "_scan_tick"}, bus.scan_tick, 0);
        check({tag, "_col_idx"},   bus.col_idx,   0);
        check({tag, "_col_sel"},   bus.col_sel,   5'b00001);
    endtask

    initial begin
        int nt;
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        reset_n = 0;
        cyc(3);
        check_reset_state("rst0");
        reset_n = 1;

        // start at cycle 0 -> ticks at 10, 20, 30
        cmd(1, 0, 0);
        check("run_running", bus.running, 1);
        cyc(10); check("t10_tick", bus.sec_tick, 1); check("t10_cnt", bus.sec_count, 0);
        cyc(1);  check("t11_tick", bus.sec_tick, 0); check("t11_cnt", bus.sec_count, 1);
        cyc(9);  check("t20_tick", bus.sec_tick, 1);
        cyc(1);  check("t21_cnt", bus.sec_count, 2);
        cyc(9);  check("t30_tick", bus.sec_tick, 1);
        cyc(1);  check("t31_cnt", bus.sec_count, 3);

        // pause at cycle 4, resume at cycle 11 -> first tick at 17
        cmd(1, 0, 0);
        cyc(3);
        cmd(0, 0, 1);
        check("p4_paused", bus.paused, 1); check("p4_running", bus.running, 0);
        cyc(6);  check("p10_tick", bus.sec_tick, 0); check("p10_paused", bus.paused, 1);
        cmd(0, 0, 1);
        check("p11_running", bus.running, 1);
        cyc(5);  check("p16_tick", bus.sec_tick, 0);
        cyc(1);  check("p17_tick", bus.sec_tick, 1);
        cyc(1);  check("p18_cnt", bus.sec_count, 1);

        // 60th tick wraps 59 -> 0 with min_tick
        cmd(1, 0, 0);
        cyc(600);
        check("m600_tick", bus.sec_tick, 1); check("m600_min", bus.min_tick, 1);
        check("m600_cnt", bus.sec_count, 59);
        cyc(1);  check("m601_cnt", bus.sec_count, 0); check("m601_min", bus.min_tick, 0);

        // stop sampled while sec_tick is high: clear wins over increment
        cyc(9);  check("s610_tick", bus.sec_tick, 1);
        cmd(0, 1, 0);
        check("s611_cnt", bus.sec_count, 0); check("s611_running", bus.running, 0);
        // pause in IDLE is ignored
        cmd(0, 0, 1);
        check("idle_pause", bus.paused, 0);

        // stop+start+pause together at sec_count 7 -> IDLE, no ticks after
        cmd(1, 0, 0);
        cyc(75); check("c75_cnt", bus.sec_count, 7);
        cmd(1, 1, 1);
        check("all_running", bus.running, 0); check("all_paused", bus.paused, 0);
        check("all_cnt", bus.sec_count, 0);
        nt = 0;
        repeat (25) begin cyc(1); nt += int'(bus.sec_tick); end
        check("all_no_tick", nt, 0);

        // reset mid-run
        cmd(1, 0, 0);
        cyc(23);
        reset_n = 0;
        cyc(3);
        check_reset_state("rst1");
        reset_n = 1;

        // free-run scan for 40 cycles
        nt = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            nt += int'(bus.scan_tick);
            if (i == 4) begin
                check("sc4_tick", bus.scan_tick, 1);
                check("sc4_col", bus.col_idx, 0);
                check("sc4_sel", bus.col_sel, BLANK ? 5'b00000 : 5'b00001);
            end
            if (i == 5) begin
                check("sc5_col", bus.col_idx, 1);
                check("sc5_sel", bus.col_sel, 5'b00010);
            end
        end
        check("sc_ticks", nt, 10);
        check("sc40_col", bus.col_idx, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
